register_bank_ff: RTL and testbench

- Parametrised multi-entry successor to the single register flip-flop primitive.
- Provides NrOfRegs words of NrOfBits each, one write port, two read ports with tri-state output enables, and whole-bank preset.
- Adds optional register-0 hardwiring, write-to-read bypass, and per-entry valid tracking.
- Used as the architectural register file in the single-cycle RISC-V datapath and as generic scratch storage elsewhere.

---
 rtl/register_bank_ff.sv | 99 +++++++++
 tb/tb_register_bank_ff.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_ff.sv
// Multi-entry register bank: one write port, two tri-stated read ports, async reset/preset,
// optional hardwired entry 0, optional write-to-read bypass and per-entry valid tracking.
module register_bank_ff #(
   parameter int NrOfBits    = 32,
   parameter int NrOfRegs    = 32,
   parameter int AddrBits    = 5,
   parameter bit ActiveLevel = 1'b1,
   parameter bit ZeroReg0    = 1'b1,
   parameter bit Bypass      = 1'b0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic                pre,
   input  logic                WrEn,
   input  logic [AddrBits-1:0] WrAddr,
   input  logic [NrOfBits-1:0] WrData,
   input  logic [AddrBits-1:0] RdAddrA,
   input  logic [AddrBits-1:0] RdAddrB,
   input  logic                csA,
   input  logic                csB,
   output logic [NrOfBits-1:0] QA,
   output logic [NrOfBits-1:0] QB,
   output logic                ValidA,
   output logic                ValidB,
   output logic [AddrBits:0]   WrCount
);

   localparam logic [AddrBits:0] FULL_COUNT = (AddrBits + 1)'(NrOfRegs);

   if (AddrBits != $clog2(NrOfRegs)) begin : g_bad_addr_bits
      $error("register_bank_ff: AddrBits must equal log2(NrOfRegs)");
   end

   logic [NrOfBits-1:0] regs [NrOfRegs];
   logic [NrOfRegs-1:0] valid;
   logic [AddrBits:0]   count;
   logic                update;
   logic                state_clk;
   logic                zero_wr;

   // A single storage edge: inverting the clock lets one process serve both polarities.
   assign state_clk = ActiveLevel ? Clock : ~Clock;
   assign update    = ClockEnable & Tick & WrEn;
   assign zero_wr   = ZeroReg0 && (WrAddr == '0);

   always_ff @(posedge state_clk or posedge Reset or posedge pre) begin
      if (Reset) begin
         // NOTE: the bank is built from flops, not a RAM macro, so every word
         // legitimately takes the asynchronous reset and preset.
         for (int i = 0; i < NrOfRegs; i++) regs[i] <= '0;
         valid <= '0;
         count <= '0;
      end else if (pre) begin
         for (int i = 0; i < NrOfRegs; i++) regs[i] <= (ZeroReg0 && i == 0) ? '0 : '1;
         valid <= '1;
         count <= FULL_COUNT;
      end else if (update) begin
         // NOTE: non-blocking assignments here so the valid[] test below sees the
         // pre-edge value and count cannot double-increment on a rewrite.
         if (!zero_wr) regs[WrAddr] <= WrData;
         valid[WrAddr] <= 1'b1;
         if (!valid[WrAddr]) count <= count + 1'b1;
      end
   end

   logic [NrOfBits-1:0] data_a, data_b;
   logic                vld_a, vld_b;

   always_comb begin
      // NOTE: every output of this block is assigned first, so no latch is inferred.
      data_a = regs[RdAddrA];
      vld_a  = valid[RdAddrA];
      if (Bypass && update && (RdAddrA == WrAddr)) begin
         data_a = WrData;
         vld_a  = 1'b1;
      end
      if (ZeroReg0 && (RdAddrA == '0)) data_a = '0;
   end

   always_comb begin
      data_b = regs[RdAddrB];
      vld_b  = valid[RdAddrB];
      if (Bypass && update && (RdAddrB == WrAddr)) begin
         data_b = WrData;
         vld_b  = 1'b1;
      end
      if (ZeroReg0 && (RdAddrB == '0)) data_b = '0;
   end

   // Only the data buses float; valid flags and the count are always driven.
   assign QA      = csA ? 'z : data_a;
   assign QB      = csB ? 'z : data_b;
   assign ValidA  = vld_a;
   assign ValidB  = vld_b;
   assign WrCount = count;

endmodule

// File: tb/tb_register_bank_ff.sv
// Directed bench for register_bank_ff: a default instance (rising edge, hardwired entry 0,
// no bypass) and an alternate one (falling edge, bypass, plain entry 0) share one stimulus.
module tb_register_bank_ff;

   logic        clk = 1'b0;
   logic        rst, ce, tick, pre, we, csa, csb;
   logic [4:0]  wa, ra, rb;
   logic [31:0] wd;

   wire  [31:0] qa_s, qb_s, qa_a, qb_a;
   logic        va_s, vb_s, va_a, vb_a;
   logic [5:0]  cnt_s, cnt_a;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   register_bank_ff u_std (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick), .pre(pre),
      .WrEn(we), .WrAddr(wa), .WrData(wd), .RdAddrA(ra), .RdAddrB(rb),
      .csA(csa), .csB(csb), .QA(qa_s), .QB(qb_s),
      .ValidA(va_s), .ValidB(vb_s), .WrCount(cnt_s)
   );

   register_bank_ff #(.ActiveLevel(1'b0), .ZeroReg0(1'b0), .Bypass(1'b1)) u_alt (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick), .pre(pre),
      .WrEn(we), .WrAddr(wa), .WrData(wd), .RdAddrA(ra), .RdAddrB(rb),
      .csA(csa), .csB(csb), .QA(qa_a), .QB(qb_a),
      .ValidA(va_a), .ValidB(vb_a), .WrCount(cnt_a)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic wait_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pre = 1'b0; ce = 1'b0; tick = 1'b0; we = 1'b0;
      csa = 1'b0; csb = 1'b0; wa = '0; wd = '0; ra = 5'd5; rb = 5'd5;
      wait_pos();
      check("rst_qa", qa_s, 0);
      check("rst_qb", qb_s, 0);
      check("rst_va", va_s, 0);
      check("rst_vb", vb_s, 0);
      check("rst_cnt", cnt_s, 0);
      check("rst_cnt_alt", cnt_a, 0);

      // First write to reg 5; the bypass instance shows it before any edge
      rst = 1'b0; ce = 1'b1; tick = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      #1;
      check("byp_qa_alt", qa_a, 32'hDEADBEEF);
      check("byp_va_alt", va_a, 1);
      check("nobyp_qa", qa_s, 0);
      check("nobyp_va", va_s, 0);
      wait_neg();
      check("fall_cnt_alt", cnt_a, 1);
      check("fall_cnt_std", cnt_s, 0);
      wait_pos();
      check("w5_qa", qa_s, 32'hDEADBEEF);
      check("w5_va", va_s, 1);
      check("w5_cnt", cnt_s, 1);
      check("w5_cnt_alt", cnt_a, 1);
      we = 1'b0;
      #1;
      check("w5_qa_alt_stored", qa_a, 32'hDEADBEEF);

      // Tick low holds everything, including bypass
      we = 1'b1; wa = 5'd7; wd = 32'h00000077; tick = 1'b0; ra = 5'd7;
      wait_pos();
      check("notick_cnt", cnt_s, 1);
      check("notick_cnt_alt", cnt_a, 1);
      check("notick_va", va_s, 0);
      check("notick_va_alt", va_a, 0);
      check("notick_qa_alt", qa_a, 0);
      tick = 1'b1;
      #1;
      check("tick_byp_alt", qa_a, 32'h00000077);
      wait_neg();
      check("tick_cnt_alt", cnt_a, 2);
      check("tick_cnt_std_wait", cnt_s, 1);
      wait_pos();
      check("tick_cnt", cnt_s, 2);
      check("tick_qa", qa_s, 32'h00000077);
      check("tick_va", va_s, 1);

      // Rewrite of reg 7 leaves the count alone
      wd = 32'h00000088;
      wait_neg();
      check("rew_cnt_alt", cnt_a, 2);
      wait_pos();
      check("rew_cnt", cnt_s, 2);
      check("rew_qa", qa_s, 32'h00000088);

      // Write driven after a rising edge, withdrawn before the next rising edge
      wa = 5'd9; wd = 32'h00000099; ra = 5'd9;
      wait_neg();
      we = 1'b0;
      wait_pos();
      check("fallonly_qa_alt", qa_a, 32'h00000099);
      check("fallonly_cnt_alt", cnt_a, 3);
      check("fallonly_va_std", va_s, 0);
      check("fallonly_cnt_std", cnt_s, 2);

      // Write driven after a falling edge, withdrawn before the next falling edge
      wait_neg();
      we = 1'b1; wa = 5'd10; wd = 32'h000000AA; ra = 5'd10;
      wait_pos();
      we = 1'b0;
      #1;
      check("riseonly_va_alt", va_a, 0);
      check("riseonly_cnt_alt", cnt_a, 3);
      check("riseonly_qa_std", qa_s, 32'h000000AA);
      check("riseonly_cnt_std", cnt_s, 3);

      // Entry 0: hardwired in u_std, ordinary in u_alt
      we = 1'b1; wa = 5'd0; wd = 32'h00001234; ra = 5'd0; rb = 5'd0;
      #1;
      check("z0_byp_alt", qa_a, 32'h00001234);
      check("z0_qa_pre", qa_s, 0);
      wait_pos();
      we = 1'b0;
      #1;
      check("z0_qa", qa_s, 0);
      check("z0_va", va_s, 1);
      check("z0_cnt", cnt_s, 4);
      check("z0_qa_alt", qa_a, 32'h00001234);
      check("z0_cnt_alt", cnt_a, 4);

      // Same-cycle read of the address being written
      we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; rb = 5'd3;
      #1;
      check("b3_qb_std_old", qb_s, 0);
      check("b3_vb_std", vb_s, 0);
      check("b3_qb_alt", qb_a, 32'hA5A5A5A5);
      check("b3_vb_alt", vb_a, 1);
      wait_neg();
      check("b3_cnt_alt", cnt_a, 5);
      check("b3_qb_std_still_old", qb_s, 0);
      wait_pos();
      check("b3_qb_std", qb_s, 32'hA5A5A5A5);
      check("b3_cnt_std", cnt_s, 5);
      we = 1'b0;
      #1;
      check("b3_qb_alt_stored", qb_a, 32'hA5A5A5A5);

      // Chip selects float data only
      ra = 5'd5; rb = 5'd5; csa = 1'b1; csb = 1'b0;
      #1;
      checks++;
      assert (qa_s === {32{1'bz}}) else begin
         errors++;
         $error("FAIL csa_hiz observed=%h expected=z", qa_s);
      end
      check("csa_qb", qb_s, 32'hDEADBEEF);
      check("csa_va", va_s, 1);
      csa = 1'b0; csb = 1'b1;
      #1;
      checks++;
      assert (qb_a === {32{1'bz}}) else begin
         errors++;
         $error("FAIL csb_hiz_alt observed=%h expected=z", qb_a);
      end
      check("csb_qa_alt", qa_a, 32'hDEADBEEF);
      check("csb_vb_alt", vb_a, 1);
      csb = 1'b0;

      // Reset pulsed between edges during a write burst
      we = 1'b1; wa = 5'd12; wd = 32'h11112222;
      wait_pos();
      check("burst_cnt", cnt_s, 6);
      check("burst_cnt_alt", cnt_a, 6);
      #2 rst = 1'b1;
      #1;
      check("arst_qa", qa_s, 0);
      check("arst_qa_alt", qa_a, 0);
      check("arst_va", va_s, 0);
      check("arst_cnt", cnt_s, 0);
      check("arst_cnt_alt", cnt_a, 0);
      rst = 1'b0; ra = 5'd12;
      wait_pos();
      check("post_rst_qa", qa_s, 32'h11112222);
      check("post_rst_va", va_s, 1);
      check("post_rst_cnt", cnt_s, 1);
      check("post_rst_cnt_alt", cnt_a, 1);
      we = 1'b0;

      // Preset, then a write with WrEn held through the release
      pre = 1'b1; ra = 5'd0; rb = 5'd1;
      #1;
      check("pre_qa0", qa_s, 0);
      check("pre_qb1", qb_s, 32'hFFFFFFFF);
      check("pre_va0", va_s, 1);
      check("pre_cnt", cnt_s, 32);
      check("pre_qa0_alt", qa_a, 32'hFFFFFFFF);
      check("pre_cnt_alt", cnt_a, 32);
      pre = 1'b0; we = 1'b1; wa = 5'd1; wd = 32'h00000005;
      wait_pos();
      check("postpre_qb", qb_s, 32'h00000005);
      check("postpre_cnt_sat", cnt_s, 32);
      check("postpre_qb_alt", qb_a, 32'h00000005);
      we = 1'b0;

      // Reset wins over preset
      rst = 1'b1; pre = 1'b1;
      #1;
      check("both_cnt", cnt_s, 0);
      check("both_qb", qb_s, 0);
      check("both_cnt_alt", cnt_a, 0);
      pre = 1'b0;
      #1 rst = 1'b0;
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
